alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single execute-stage ALU between two requesters, the main execute path (port 0) and the address/auxiliary path (port 1), using round-robin arbitration with valid/ready handshakes. It drives the ALU's operand, command and carry-in inputs and registers the result into a one-entry response buffer. It also owns the architectural NZCV status register that supplies the ALU carry-in and is updated by flag-setting operations.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. Fixed to the ALU width.
- `NREQ`, 2: number of requesters. Fixed at 2.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `reqValid` in 2: per-requester request valid.
- `reqReady` out 2: per-requester grant/accept. One-hot or zero; combinational from state and `reqValid`.
- `reqCmd0`, `reqCmd1` in 4: ALU command per requester.
- `reqVal1_0`, `reqVal1_1` in 32: first operand per requester.
- `reqVal2_0`, `reqVal2_1` in 32: second operand per requester.
- `reqS` in 2: per-requester set-status bit.
- `rspValid` out 1: response buffer holds a result.
- `rspReady` in 1: consumer accepts the response.
- `rspId` out 1: requester that owns the response.
- `rspResult` out 32: registered ALU result.
- `rspFlags` out 4: NZCV computed for this operation, `{N,Z,C,V}`, whether or not it was committed.
- `status` out 4: architectural NZCV register.
- `aluVal1`, `aluVal2` out 32: to ALU.
- `aluCmd` out 4: to ALU.
- `aluCarryIn` out 1: to ALU. Always equals `status[1]` (C).
- `aluOut` in 32: from ALU.
- `aluOvf` in 1: ALU signed-overflow output.
- `aluCarryOut` in 1: from ALU.

## Operation
- Two states:
  - IDLE: response buffer empty.
  - FULL: response buffer holds a result.
- Grant is allowed when in IDLE, or when in FULL with `rspValid && rspReady` in the same cycle (drain-and-refill, throughput 1 op/cycle).
- Arbitration is round-robin using `lastGrant` (1 bit).
  - If both requesters are valid, the one that is not `lastGrant` wins.
  - If one is valid, it wins.
  - `lastGrant` resets to 1, so requester 0 wins the first contested cycle.
- ALU inputs are muxed from the winner.
  - When no grant occurs, the ALU inputs hold the port-0 fields and `aluCmd` = 4'b0000, whose ALU result is 0.
- On grant, at the clock edge:
  - `rspResult` ← `aluOut`, `rspId` ← winner, `rspFlags` ← computed flags, state ← FULL, `lastGrant` ← winner.
- Flag computation:
  - N = `aluOut[31]`.
  - Z = (`aluOut` == 0).
  - Arithmetic commands (4'b0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC): C = `aluCarryOut`, V = `aluOvf`.
  - All other commands (MOV 0001, MVN 1001, AND 0110, ORR 0111, EOR 1000): C and V are unchanged from `status`.
- `status` is written with the computed flags on the grant edge only if the winner's `reqS` bit is 1.
- Response accept with no new grant: state ← IDLE.
- An unknown `aluCmd` is passed through unchanged; the ALU then holds its previous output, and the block registers whatever `aluOut` presents.

## Timing
- Reset values:
  - `rspValid` = 0, `rspId` = 0, `rspResult` = 0, `rspFlags` = 0, `status` = 4'b0000, `reqReady` = 0, `lastGrant` = 1, state IDLE.
- Latency: grant in cycle T gives `rspValid` = 1 in cycle T+1.
- Back-to-back: an op granted in T+1 sees the `status` updated at the end of T, so chained ADC/SBC use the correct carry.
- Backpressure: while `rspValid && !rspReady`, `reqReady` = 0 and `rspResult`, `rspId` and `rspFlags` are held stable.
- A request must hold `reqValid` and its fields until `reqReady` is seen; the block never drops an accepted request.
- Reset mid-operation clears the buffer immediately, with no response emitted.
- A request present when reset deasserts is arbitrated in the first cycle after deassertion.

## Structure
- Shared package holds:
  - ALU command constants (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR).
  - Flag bit indices N=3, Z=2, C=1, V=0.
  - The state encoding.
- The ALU is instantiated outside this block; this block only connects to its ports.
- One sub-module is natural: `rr_arbiter2`, a 2-way round-robin grant with its pointer register.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `status` = 0000, `rspValid` = 0, `reqReady` = 00 immediately.
- Requester 0 ADD with `reqS` = 1, `0x7FFFFFFF + 0x00000001` → next cycle `rspResult` = `0x80000000`, `rspFlags` = 1001, `status` = 1001.
- Both requesters valid for 4 ops each, `rspReady` held at 1 → grants alternate 0,1,0,1…, one response per cycle, `rspId` matches the grant order.
- SUB `5 - 5` with S=1, then ADC `3 + 4` with S=0 → `status` = 0110 after the SUB, ADC result = 8, `status` unchanged.
- `rspReady` = 0 for 3 cycles with both requesters valid → `reqReady` = 00 throughout, response held; after the accept, the next grant goes to the other requester.
- AND `0xF0 & 0x0F` with S=1 while `status` = 0011 → result 0, `status` = 0111 (C and V preserved).

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU command codes, NZCV bit positions and response-buffer state encoding.
// No logic and no latency; the helper below is purely combinational.
package alu_arbiter_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // Only these commands produce meaningful carry/overflow from the ALU.
    function automatic logic is_arith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_ADC) || (cmd == CMD_SUB) || (cmd == CMD_SBC);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; combinational from requests/enable, pointer updated on grant.
// The loser of a contested cycle wins the next contested cycle; no grant while i_en is low.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt,
    output logic       o_winner
);

    logic r_last_grant;
    logic w_winner;
    logic w_grant;

    always_comb begin
        w_winner = 1'b0;
        if (i_req == 2'b11) begin
            w_winner = ~r_last_grant;
        end else if (i_req[1]) begin
            w_winner = 1'b1;
        end
    end

    assign w_grant  = i_en && (|i_req);
    assign o_gnt    = w_grant ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign o_winner = w_winner;

    // Pointer resets to requester 1 so requester 0 takes the first contested cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters, registers the result in a one-entry response buffer and owns NZCV.
// Result appears the cycle after grant; no grant while a held response is not being accepted.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  reqValid,
    output logic [NREQ-1:0]  reqReady,
    input  logic [3:0]       reqCmd0,
    input  logic [3:0]       reqCmd1,
    input  logic [WIDTH-1:0] reqVal1_0,
    input  logic [WIDTH-1:0] reqVal1_1,
    input  logic [WIDTH-1:0] reqVal2_0,
    input  logic [WIDTH-1:0] reqVal2_1,
    input  logic [NREQ-1:0]  reqS,
    output logic             rspValid,
    input  logic             rspReady,
    output logic             rspId,
    output logic [WIDTH-1:0] rspResult,
    output logic [3:0]       rspFlags,
    output logic [3:0]       status,
    output logic [WIDTH-1:0] aluVal1,
    output logic [WIDTH-1:0] aluVal2,
    output logic [3:0]       aluCmd,
    output logic             aluCarryIn,
    input  logic [WIDTH-1:0] aluOut,
    input  logic             aluOvf,
    input  logic             aluCarryOut
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_grant_en;
    logic             w_grant;
    logic             w_winner;
    logic [NREQ-1:0]  w_gnt;
    logic             w_set;
    logic [3:0]       w_flags;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic [3:0]       r_status;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req    (reqValid),
        .i_en     (w_grant_en),
        .o_gnt    (w_gnt),
        .o_winner (w_winner)
    );

    assign w_grant  = |w_gnt;
    assign reqReady = w_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && rspReady) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Gating with rst keeps reqReady low for the whole reset window, not just after the edge.
    always_comb begin
        rspValid   = (r_state == ST_FULL);
        w_grant_en = !rst && ((r_state == ST_IDLE) || rspReady);
    end

    always_comb begin
        aluVal1 = reqVal1_0;
        aluVal2 = reqVal2_0;
        aluCmd  = CMD_NOP;
        w_set   = reqS[0];
        if (w_grant) begin
            aluCmd = reqCmd0;
            if (w_winner) begin
                aluVal1 = reqVal1_1;
                aluVal2 = reqVal2_1;
                aluCmd  = reqCmd1;
                w_set   = reqS[1];
            end
        end
    end

    assign aluCarryIn = r_status[FLAG_C];

    always_comb begin
        w_flags         = r_status;
        w_flags[FLAG_N] = aluOut[WIDTH-1];
        w_flags[FLAG_Z] = (aluOut == '0);
        if (is_arith(aluCmd)) begin
            w_flags[FLAG_C] = aluCarryOut;
            w_flags[FLAG_V] = aluOvf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
            r_status     <= 4'b0000;
        end else if (w_grant) begin
            r_rsp_id     <= w_winner;
            r_rsp_result <= aluOut;
            r_rsp_flags  <= w_flags;
            if (w_set) begin
                r_status <= w_flags;
            end
        end
    end

    assign rspId     = r_rsp_id;
    assign rspResult = r_rsp_result;
    assign rspFlags  = r_rsp_flags;
    assign status    = r_status;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the ALU-side ports.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [3:0]  reqCmd0, reqCmd1;
    logic [31:0] reqVal1_0, reqVal1_1, reqVal2_0, reqVal2_1;
    logic [1:0]  reqS;
    logic        rspValid;
    logic        rspReady;
    logic        rspId;
    logic [31:0] rspResult;
    logic [3:0]  rspFlags;
    logic [3:0]  status;
    logic [31:0] aluVal1, aluVal2;
    logic [3:0]  aluCmd;
    logic        aluCarryIn;
    logic [31:0] aluOut;
    logic        aluOvf;
    logic        aluCarryOut;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.WIDTH(32), .NREQ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqCmd0     (reqCmd0),
        .reqCmd1     (reqCmd1),
        .reqVal1_0   (reqVal1_0),
        .reqVal1_1   (reqVal1_1),
        .reqVal2_0   (reqVal2_0),
        .reqVal2_1   (reqVal2_1),
        .reqS        (reqS),
        .rspValid    (rspValid),
        .rspReady    (rspReady),
        .rspId       (rspId),
        .rspResult   (rspResult),
        .rspFlags    (rspFlags),
        .status      (status),
        .aluVal1     (aluVal1),
        .aluVal2     (aluVal2),
        .aluCmd      (aluCmd),
        .aluCarryIn  (aluCarryIn),
        .aluOut      (aluOut),
        .aluOvf      (aluOvf),
        .aluCarryOut (aluCarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: ARM-style carry (SUB carry = no borrow).
    logic [32:0] m_sum;
    logic [31:0] m_b;
    logic        m_arith;
    always_comb begin
        m_sum       = '0;
        m_b         = aluVal2;
        m_arith     = 1'b0;
        aluOut      = '0;
        aluOvf      = 1'b0;
        aluCarryOut = 1'b0;
        case (aluCmd)
            4'b0001: aluOut = aluVal2;
            4'b1001: aluOut = ~aluVal2;
            4'b0110: aluOut = aluVal1 & aluVal2;
            4'b0111: aluOut = aluVal1 | aluVal2;
            4'b1000: aluOut = aluVal1 ^ aluVal2;
            4'b0010: begin m_arith = 1'b1; m_sum = {1'b0, aluVal1} + {1'b0, m_b}; end
            4'b0011: begin m_arith = 1'b1; m_sum = {1'b0, aluVal1} + {1'b0, m_b} + {32'd0, aluCarryIn}; end
            4'b0100: begin m_arith = 1'b1; m_b = ~aluVal2; m_sum = {1'b0, aluVal1} + {1'b0, m_b} + 33'd1; end
            4'b0101: begin m_arith = 1'b1; m_b = ~aluVal2; m_sum = {1'b0, aluVal1} + {1'b0, m_b} + {32'd0, aluCarryIn}; end
            default: aluOut = '0;
        endcase
        if (m_arith) begin
            aluOut      = m_sum[31:0];
            aluCarryOut = m_sum[32];
            aluOvf      = (aluVal1[31] == m_b[31]) && (m_sum[31] != aluVal1[31]);
        end
    end

    task automatic set_req(input int port, input logic [3:0] cmd, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        if (port == 0) begin
            reqCmd0 = cmd; reqVal1_0 = a; reqVal2_0 = b; reqS[0] = s;
        end else begin
            reqCmd1 = cmd; reqVal1_1 = a; reqVal2_1 = b; reqS[1] = s;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        reqValid = 2'b00;
        reqS     = 2'b00;
        rspReady = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqValid = 2'b11;
        set_req(0, 4'b0010, 32'd1, 32'd2, 1'b1);
        set_req(1, 4'b0010, 32'd3, 32'd4, 1'b1);
        rspReady = 1'b1;
        @(negedge clk);
        n_checks++; if (rspValid !== 1'b0) begin n_fail++; $display("FAIL reset_rspValid got %b want 0", rspValid); end
        n_checks++; if (rspId !== 1'b0) begin n_fail++; $display("FAIL reset_rspId got %b want 0", rspId); end
        n_checks++; if (rspResult !== 32'd0) begin n_fail++; $display("FAIL reset_rspResult got %h want 0", rspResult); end
        n_checks++; if (rspFlags !== 4'b0000) begin n_fail++; $display("FAIL reset_rspFlags got %b want 0000", rspFlags); end
        n_checks++; if (status !== 4'b0000) begin n_fail++; $display("FAIL reset_status got %b want 0000", status); end
        n_checks++; if (reqReady !== 2'b00) begin n_fail++; $display("FAIL reset_reqReady got %b want 00", reqReady); end
        reqValid = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_idle_mux();
        do_reset();
        set_req(0, 4'b0010, 32'h11, 32'h22, 1'b1);
        reqValid = 2'b00;
        #1;
        n_checks++; if (aluCmd !== 4'b0000) begin n_fail++; $display("FAIL idle_aluCmd got %b want 0000", aluCmd); end
        n_checks++; if (aluVal1 !== 32'h11) begin n_fail++; $display("FAIL idle_aluVal1 got %h want 11", aluVal1); end
        n_checks++; if (aluVal2 !== 32'h22) begin n_fail++; $display("FAIL idle_aluVal2 got %h want 22", aluVal2); end
        @(negedge clk);
        n_checks++; if (rspValid !== 1'b0) begin n_fail++; $display("FAIL idle_rspValid got %b want 0", rspValid); end
    endtask

    task automatic test_add_flags();
        do_reset();
        set_req(0, 4'b0010, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        reqValid = 2'b01;
        #1;
        n_checks++; if (reqReady !== 2'b01) begin n_fail++; $display("FAIL add_reqReady got %b want 01", reqReady); end
        @(negedge clk);
        reqValid = 2'b00;
        n_checks++; if (rspValid !== 1'b1) begin n_fail++; $display("FAIL add_rspValid got %b want 1", rspValid); end
        n_checks++; if (rspResult !== 32'h80000000) begin n_fail++; $display("FAIL add_rspResult got %h want 80000000", rspResult); end
        n_checks++; if (rspFlags !== 4'b1001) begin n_fail++; $display("FAIL add_rspFlags got %b want 1001", rspFlags); end
        n_checks++; if (status !== 4'b1001) begin n_fail++; $display("FAIL add_status got %b want 1001", status); end
        n_checks++; if (rspId !== 1'b0) begin n_fail++; $display("FAIL add_rspId got %b want 0", rspId); end
        @(negedge clk);
        n_checks++; if (rspValid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b want 0", rspValid); end
    endtask

    task automatic test_round_robin();
        int          cnt0;
        int          cnt1;
        logic        win;
        logic [31:0] exp_res;
        cnt0 = 0; cnt1 = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_req(0, 4'b0010, 32'h100 + cnt0, cnt0, 1'b0);
            set_req(1, 4'b1000, 32'hFF00, cnt1, 1'b0);
            reqValid = {cnt1 < 4, cnt0 < 4};
            win = c[0];
            exp_res = win ? (32'hFF00 ^ cnt1) : (32'h100 + 2 * cnt0);
            #1;
            n_checks++; if (reqReady !== (win ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_reqReady[%0d] got %b want %b", c, reqReady, win ? 2'b10 : 2'b01); end
            @(negedge clk);
            n_checks++; if (rspValid !== 1'b1) begin n_fail++; $display("FAIL rr_rspValid[%0d] got %b want 1", c, rspValid); end
            n_checks++; if (rspId !== win) begin n_fail++; $display("FAIL rr_rspId[%0d] got %b want %b", c, rspId, win); end
            n_checks++; if (rspResult !== exp_res) begin n_fail++; $display("FAIL rr_rspResult[%0d] got %h want %h", c, rspResult, exp_res); end
            if (win) cnt1++; else cnt0++;
        end
        reqValid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_sub_adc_chain();
        do_reset();
        set_req(0, 4'b0100, 32'd5, 32'd5, 1'b1);
        reqValid = 2'b01;
        @(negedge clk);
        n_checks++; if (status !== 4'b0110) begin n_fail++; $display("FAIL sub_status got %b want 0110", status); end
        n_checks++; if (rspResult !== 32'd0) begin n_fail++; $display("FAIL sub_rspResult got %h want 0", rspResult); end
        set_req(0, 4'b0011, 32'd3, 32'd4, 1'b0);
        #1;
        n_checks++; if (aluCarryIn !== 1'b1) begin n_fail++; $display("FAIL adc_carryIn got %b want 1", aluCarryIn); end
        @(negedge clk);
        reqValid = 2'b00;
        n_checks++; if (rspResult !== 32'd8) begin n_fail++; $display("FAIL adc_rspResult got %h want 8", rspResult); end
        n_checks++; if (rspFlags !== 4'b0000) begin n_fail++; $display("FAIL adc_rspFlags got %b want 0000", rspFlags); end
        n_checks++; if (status !== 4'b0110) begin n_fail++; $display("FAIL adc_status got %b want 0110", status); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        rspReady = 1'b0;
        set_req(0, 4'b0010, 32'd1, 32'd1, 1'b0);
        set_req(1, 4'b0010, 32'd2, 32'd2, 1'b0);
        reqValid = 2'b11;
        #1;
        n_checks++; if (reqReady !== 2'b01) begin n_fail++; $display("FAIL bp_first_grant got %b want 01", reqReady); end
        @(negedge clk);
        reqValid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (reqReady !== 2'b00) begin n_fail++; $display("FAIL bp_reqReady[%0d] got %b want 00", c, reqReady); end
            n_checks++; if (rspResult !== 32'd2 || rspId !== 1'b0 || rspValid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b id=%b res=%h want v=1 id=0 res=2", c, rspValid, rspId, rspResult);
            end
            @(negedge clk);
        end
        reqValid = 2'b11;
        rspReady = 1'b1;
        #1;
        n_checks++; if (reqReady !== 2'b10) begin n_fail++; $display("FAIL bp_refill_grant got %b want 10", reqReady); end
        @(negedge clk);
        reqValid = 2'b00;
        n_checks++; if (rspId !== 1'b1 || rspResult !== 32'd4) begin n_fail++; $display("FAIL bp_refill_rsp got id=%b res=%h want id=1 res=4", rspId, rspResult); end
        @(negedge clk);
        n_checks++; if (rspValid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", rspValid); end
    endtask

    task automatic test_logic_flags();
        do_reset();
        set_req(1, 4'b0010, 32'h80000000, 32'h80000001, 1'b1);
        reqValid = 2'b10;
        @(negedge clk);
        n_checks++; if (status !== 4'b0011) begin n_fail++; $display("FAIL prep_status got %b want 0011", status); end
        set_req(1, 4'b0110, 32'hF0, 32'h0F, 1'b1);
        @(negedge clk);
        reqValid = 2'b00;
        n_checks++; if (rspResult !== 32'd0) begin n_fail++; $display("FAIL and_rspResult got %h want 0", rspResult); end
        n_checks++; if (status !== 4'b0111) begin n_fail++; $display("FAIL and_status got %b want 0111", status); end
        n_checks++; if (rspId !== 1'b1) begin n_fail++; $display("FAIL and_rspId got %b want 1", rspId); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        do_reset();
        rspReady = 1'b0;
        set_req(0, 4'b0010, 32'h80000000, 32'h80000000, 1'b1);
        reqValid = 2'b01;
        @(negedge clk);
        n_checks++; if (status !== 4'b0111 || rspValid !== 1'b1) begin n_fail++; $display("FAIL midrst_prep got st=%b v=%b want st=0111 v=1", status, rspValid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (rspValid !== 1'b0) begin n_fail++; $display("FAIL midrst_rspValid got %b want 0", rspValid); end
        n_checks++; if (status !== 4'b0000) begin n_fail++; $display("FAIL midrst_status got %b want 0000", status); end
        n_checks++; if (reqReady !== 2'b00) begin n_fail++; $display("FAIL midrst_reqReady got %b want 00", reqReady); end
        @(negedge clk);
        set_req(1, 4'b0111, 32'h5, 32'hA, 1'b0);
        reqValid = 2'b10;
        rst = 1'b0;
        #1;
        n_checks++; if (reqReady !== 2'b10) begin n_fail++; $display("FAIL postrst_reqReady got %b want 10", reqReady); end
        @(negedge clk);
        reqValid = 2'b00;
        n_checks++; if (rspValid !== 1'b1 || rspId !== 1'b1 || rspResult !== 32'hF) begin
            n_fail++; $display("FAIL postrst_rsp got v=%b id=%b res=%h want v=1 id=1 res=f", rspValid, rspId, rspResult);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        reqValid  = 2'b00;
        reqS      = 2'b00;
        rspReady  = 1'b0;
        reqCmd0   = 4'b0000; reqCmd1   = 4'b0000;
        reqVal1_0 = '0; reqVal1_1 = '0; reqVal2_0 = '0; reqVal2_1 = '0;
        test_reset();
        test_idle_mux();
        test_add_flags();
        test_round_robin();
        test_sub_adc_chain();
        test_backpressure();
        test_logic_flags();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
